// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and RX state encodings for the UART block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 8;
    localparam int DATA_BITS  = 8;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_IDLE  = 3'd0;
    localparam rx_state_t ST_START = 3'd1;
    localparam rx_state_t ST_DATA  = 3'd2;
    localparam rx_state_t ST_STOP  = 3'd3;
    localparam rx_state_t ST_BREAK = 3'd4;

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module      : uart_baud_tick
// Description : Oversample tick generator; one-clk tick every DIVISOR clks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
    parameter int DIVISOR = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_clr,
    output logic tick
);

    localparam int                 c_cnt_w = $clog2(DIVISOR);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIVISOR - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;

    // sync_clr re-phases the divider so ticks line up with the frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (sync_clr || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_one;
        end
    end

    assign tick = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : 16x oversampled 8N1 receiver with valid/ready byte handoff.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int DIVISOR = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    input  logic       clr_err
);

    localparam logic [3:0] c_mid_last = 4'(MID_TICK - 1);
    localparam logic [3:0] c_os_last  = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] c_bit_last = 3'(DATA_BITS - 1);

    logic            r_sync1;
    logic            r_rx_s;
    logic            r_rx_prev;
    rx_state_t       r_state;
    logic [3:0]      r_tick_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_frame_err;
    logic            r_overrun;

    logic            w_fall;
    logic            w_tick;
    logic            w_sync_clr;
    logic            w_bit_end;
    logic            w_good;
    logic            w_bad;

    assign w_fall     = r_rx_prev & ~r_rx_s;
    assign w_sync_clr = (r_state == ST_IDLE) & w_fall;
    assign w_bit_end  = w_tick & (r_tick_cnt == c_os_last);
    assign w_good     = (r_state == ST_STOP) & w_bit_end & r_rx_s;
    assign w_bad      = (r_state == ST_STOP) & w_bit_end & ~r_rx_s;

    uart_baud_tick #(
        .DIVISOR (DIVISOR)
    ) u_baud_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .sync_clr (w_sync_clr),
        .tick     (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state    <= ST_START;
                        r_tick_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_mid_last) begin
                            r_tick_cnt <= '0;
                            r_bit_idx  <= '0;
                            r_state    <= r_rx_s ? ST_IDLE : ST_DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                        if (w_bit_end) begin
                            r_shift <= {r_rx_s, r_shift[7:1]};
                            if (r_bit_idx == c_bit_last) begin
                                r_state <= ST_STOP;
                            end else begin
                                r_bit_idx <= r_bit_idx + 3'd1;
                            end
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                        if (w_bit_end) begin
                            r_state <= r_rx_s ? ST_IDLE : ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    if (r_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // A byte landing in the same cycle as an accept replaces the old one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_bad;
            if (w_good && (!r_valid || ready)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
            if (w_good && r_valid && !ready) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign data_out  = r_data;
    assign valid     = r_valid;
    assign busy      = (r_state != ST_IDLE);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Scoreboard testbench for uart_rx (DIVISOR=4, 64 clk per bit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       ready;
    logic       clr_err;
    logic [7:0] data_out;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         fe_count = 0;
    logic [7:0] exp_q[$];

    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_fe    = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(
        .DIVISOR (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .clr_err   (clr_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic stop_b);
        rx = 1'b0;
        cyc(64);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            cyc(64);
        end
        rx = stop_b;
        cyc(64);
    endtask

    task automatic accept_one();
        int t;
        t = 0;
        while (!valid && t < 3000) begin
            cyc(1);
            t++;
        end
        chk("accept_wait_valid", {31'd0, valid}, 32'd1);
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
    endtask

    // Monitor: a new byte is presented when valid rises or is reloaded during an accept
    always @(negedge clk) begin
        if (valid && (!prev_valid || prev_ready)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_valid: data_out=%02h, no byte expected", data_out);
            end else begin
                chk("rx_byte", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
            end
        end
        if (frame_err) begin
            fe_count++;
            chk("frame_err_width", {31'd0, prev_fe}, 32'd0);
        end
        prev_valid = valid;
        prev_ready = ready;
        prev_fe    = frame_err;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic bad;
        rst_n   = 1'b0;
        rx      = 1'b1;
        ready   = 1'b0;
        clr_err = 1'b0;
        #2;
        chk("rst_data_out",  {24'd0, data_out},  32'h00);
        chk("rst_valid",     {31'd0, valid},     32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_overrun",   {31'd0, overrun},   32'd0);
        cyc(3);
        rst_n = 1'b1;
        cyc(5);

        // 0xBB, ready held low: valid appears right after the stop sample
        exp_q.push_back(8'hBB);
        fork
            send(8'hBB, 1'b1);
            begin
                cyc(610);
                chk("valid_before_stop", {31'd0, valid}, 32'd0);
                cyc(1);
                chk("valid_after_stop", {31'd0, valid}, 32'd1);
                chk("data_bb", {24'd0, data_out}, 32'hBB);
            end
        join
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
        chk("valid_cleared", {31'd0, valid}, 32'd0);

        // back-to-back 0x01, 0x80 with prompt accepts
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h80);
        fork
            begin
                send(8'h01, 1'b1);
                send(8'h80, 1'b1);
            end
            begin
                accept_one();
                accept_one();
            end
        join
        cyc(4);
        chk("b2b_overrun", {31'd0, overrun}, 32'd0);
        chk("b2b_no_frame_err", fe_count, 0);

        // 0x55 with bad stop, then line held low as a break
        send(8'h55, 1'b0);
        chk("framing_err_count", fe_count, 1);
        bad = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) bad = 1'b1;
            cyc(1);
        end
        chk("busy_during_break", {31'd0, bad}, 32'd0);
        rx = 1'b1;
        cyc(2);
        chk("busy_at_rx_s_high", {31'd0, busy}, 32'd1);
        cyc(1);
        chk("busy_after_break", {31'd0, busy}, 32'd0);
        chk("break_no_valid", {31'd0, valid}, 32'd0);
        cyc(10);

        // 20 clk glitch: false start
        rx = 1'b0;
        cyc(5);
        chk("glitch_busy", {31'd0, busy}, 32'd1);
        cyc(15);
        rx = 1'b1;
        cyc(40);
        chk("glitch_idle", {31'd0, busy}, 32'd0);
        chk("glitch_no_valid", {31'd0, valid}, 32'd0);
        chk("glitch_no_fe", fe_count, 1);
        chk("glitch_no_overrun", {31'd0, overrun}, 32'd0);

        // overrun: 0x22 dropped while 0x11 still pending
        exp_q.push_back(8'h11);
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        cyc(2);
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        chk("ovr_data_kept", {24'd0, data_out}, 32'h11);
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        chk("ovr_cleared", {31'd0, overrun}, 32'd0);

        // accept lands on the exact delivery cycle: new byte wins
        exp_q.push_back(8'h22);
        fork
            send(8'h22, 1'b1);
            begin
                cyc(610);
                ready = 1'b1;
                cyc(1);
                ready = 1'b0;
            end
        join
        chk("same_cycle_data", {24'd0, data_out}, 32'h22);
        chk("same_cycle_valid", {31'd0, valid}, 32'd1);
        chk("same_cycle_no_ovr", {31'd0, overrun}, 32'd0);

        // reset while bit 3 of a frame is on the line
        rx = 1'b0;
        cyc(64);
        for (int i = 0; i < 3; i++) begin
            rx = 1'b1;
            cyc(64);
        end
        rx = 1'b0;
        cyc(20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", {24'd0, data_out}, 32'h00);
        chk("mid_rst_valid", {31'd0, valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_overrun", {31'd0, overrun}, 32'd0);
        chk("mid_rst_fe", {31'd0, frame_err}, 32'd0);
        cyc(2);
        rx = 1'b1;
        rst_n = 1'b1;
        cyc(10);

        exp_q.push_back(8'hA5);
        fork
            send(8'hA5, 1'b1);
            accept_one();
        join
        cyc(4);

        chk("scoreboard_drained", exp_q.size(), 0);
        chk("frame_err_total", fe_count, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
